// File: rtl/pipe_stage_reg.sv
// Purpose : pipeline-stage register with a two-entry skid buffer, sync flush and stall counter.
// Latency : one cycle from acceptance to o_valid/o_data/o_ctrl; one entry per cycle sustained.
// Backpr. : o_ready is a flop (~skid valid); the skid entry absorbs the in-flight entry.
//
// Ports:
//   clk, reset (async, active-low), flush (sync discard), clr_stat (sync counter clear)
//   i_valid/o_ready/i_data/i_ctrl : upstream handshake and payload
//   o_valid/i_ready/o_data/o_ctrl : downstream handshake and head entry (o_ctrl=0 on bubble)
//   stall_cnt                     : saturating count of back-pressured cycles
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              clr_stat,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State encoding is {main valid, skid valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_m_data;
  logic [DATA_W-1:0]   r_s_data;
  logic [DATA_W-1:0]   w_m_data_nxt;
  logic [DATA_W-1:0]   w_s_data_nxt;
  logic [CTRL_W-1:0]   r_m_ctrl;
  logic [CTRL_W-1:0]   r_s_ctrl;
  logic [CTRL_W-1:0]   w_m_ctrl_nxt;
  logic [CTRL_W-1:0]   w_s_ctrl_nxt;
  logic                r_ready;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    w_stall_cnt_nxt;
  logic                w_acc;
  logic                w_deq;
  logic                w_m_valid;

  assign w_m_valid = r_state[1];
  assign w_acc     = i_valid & r_ready;
  assign w_deq     = w_m_valid & i_ready;

  // Next-state and storage update. Control bits are zeroed on the same edge an
  // entry goes invalid, so a bubble never carries live control downstream.
  always_comb begin
    w_state_nxt  = r_state;
    w_m_data_nxt = r_m_data;
    w_s_data_nxt = r_s_data;
    w_m_ctrl_nxt = r_m_ctrl;
    w_s_ctrl_nxt = r_s_ctrl;
    if (flush) begin
      w_state_nxt  = ST_EMPTY;
      w_m_ctrl_nxt = '0;
      w_s_ctrl_nxt = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt  = ST_ONE;
            w_m_data_nxt = i_data;
            w_m_ctrl_nxt = i_ctrl;
          end
        end
        ST_ONE: begin
          if (w_acc && w_deq) begin
            w_m_data_nxt = i_data;
            w_m_ctrl_nxt = i_ctrl;
          end else if (w_acc) begin
            w_state_nxt  = ST_FULL;
            w_s_data_nxt = i_data;
            w_s_ctrl_nxt = i_ctrl;
          end else if (w_deq) begin
            w_state_nxt  = ST_EMPTY;
            w_m_ctrl_nxt = '0;
          end
        end
        ST_FULL: begin
          // o_ready is low here, so only a dequeue can move the state.
          if (w_deq) begin
            w_state_nxt  = ST_ONE;
            w_m_data_nxt = r_s_data;
            w_m_ctrl_nxt = r_s_ctrl;
            w_s_ctrl_nxt = '0;
          end
        end
        default: begin
          // Recover from the unreachable encoding by dropping to a clean bubble.
          w_state_nxt  = ST_EMPTY;
          w_m_ctrl_nxt = '0;
          w_s_ctrl_nxt = '0;
        end
      endcase
    end
  end

  // Stall counter: clear wins over increment; saturate at all-ones.
  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    if (clr_stat) begin
      w_stall_cnt_nxt = '0;
    end else if (w_m_valid && !i_ready && !flush && !(&r_stall_cnt)) begin
      w_stall_cnt_nxt = r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_m_data    <= '0;
      r_s_data    <= '0;
      r_m_ctrl    <= '0;
      r_s_ctrl    <= '0;
      r_ready     <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_m_data    <= w_m_data_nxt;
      r_s_data    <= w_s_data_nxt;
      r_m_ctrl    <= w_m_ctrl_nxt;
      r_s_ctrl    <= w_s_ctrl_nxt;
      // Ready is registered from the next skid-valid bit: no path from i_ready/i_valid.
      r_ready     <= ~w_state_nxt[0];
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  assign o_ready   = r_ready;
  assign o_valid   = w_m_valid;
  assign o_data    = r_m_data;
  assign o_ctrl    = r_m_ctrl;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          clr_stat;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic [CW-1:0] i_ctrl;
  logic          i_ready;

  logic          o_ready,  o_valid;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_ctrl;
  logic [15:0]   stall_cnt;

  logic          o_ready2, o_valid2;
  logic [DW-1:0] o_data2;
  logic [CW-1:0] o_ctrl2;
  logic [1:0]    stall_cnt2;

  int checks = 0;
  int errors = 0;
  logic [CW+DW-1:0] sb_q[$];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .clr_stat(clr_stat),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_ctrl(i_ctrl),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_ctrl(o_ctrl),
    .stall_cnt(stall_cnt)
  );

  // Identical stimulus, narrow counter for saturation checks.
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .clr_stat(clr_stat),
    .i_valid(i_valid), .o_ready(o_ready2), .i_data(i_data), .i_ctrl(i_ctrl),
    .o_valid(o_valid2), .i_ready(i_ready), .o_data(o_data2), .o_ctrl(o_ctrl2),
    .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on acceptance, pop and compare on each downstream transfer.
  // Sampled on the falling edge, where inputs and registered outputs are stable.
  always @(negedge clk) begin
    if (reset && !flush) begin
      if (o_valid && i_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got ctrl=%0h data=%0h expected none", o_ctrl, o_data);
        end else begin
          logic [CW+DW-1:0] exp;
          exp = sb_q.pop_front();
          if ({o_ctrl, o_data} !== exp) begin
            errors++;
            $display("FAIL sb_out: got %0h expected %0h", {o_ctrl, o_data}, exp);
          end
        end
      end
      if (!o_valid) chk("bubble_ctrl", 64'(o_ctrl), 64'h0);
      if (i_valid && o_ready) sb_q.push_back({i_ctrl, i_data});
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; clr_stat = 1'b0;
    i_valid = 1'b0; i_data = '0; i_ctrl = '0; i_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    chk("rst_o_valid", 64'(o_valid), 64'h0);
    chk("rst_o_ready", 64'(o_ready), 64'h1);
    chk("rst_o_data",  64'(o_data),  64'h0);
    chk("rst_o_ctrl",  64'(o_ctrl),  64'h0);
    chk("rst_stall",   64'(stall_cnt), 64'h0);

    // Streaming 1..8 with downstream always ready.
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1; i_data = DW'(k); i_ctrl = CW'(k);
      cyc();
      chk("stream_o_valid", 64'(o_valid), 64'h1);
      chk("stream_o_data",  64'(o_data), 64'(k));
      chk("stream_o_ready", 64'(o_ready), 64'h1);
    end
    i_valid = 1'b0;
    cyc();
    chk("stream_drained", 64'(o_valid), 64'h0);

    // Back-pressure: i_ready low for cycles 3..6.
    clr_stat = 1'b1; cyc(); clr_stat = 1'b0;
    begin
      int v;
      logic accepted;
      v = 1;
      for (int c = 0; c < 16; c++) begin
        i_ready  = !(c >= 3 && c <= 6);
        i_valid  = (v <= 10);
        i_data   = DW'(v + 32'h100);
        i_ctrl   = CW'(v);
        accepted = i_valid && o_ready;
        cyc();
        if (accepted) v++;
        chk("bp_o_ready", 64'(o_ready), (c >= 3 && c <= 6) ? 64'h0 : 64'h1);
      end
      chk("bp_all_sent", 64'(v), 64'd11);
    end
    chk("bp_o_valid_end", 64'(o_valid), 64'h0);
    chk("bp_stall_cnt",   64'(stall_cnt), 64'd4);
    chk("bp_stall_cnt2",  64'(stall_cnt2), 64'd3);

    // Flush in FULL (entries 5,6) with entry 7 offered in the same cycle.
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 32'd5; i_ctrl = 4'h5; cyc();
    i_data = 32'd6; i_ctrl = 4'h6; cyc();
    chk("fl_full_ready", 64'(o_ready), 64'h0);
    i_data = 32'd7; i_ctrl = 4'h7; flush = 1'b1;
    cyc();
    flush = 1'b0; i_valid = 1'b0;
    sb_q.delete();
    chk("fl_o_valid", 64'(o_valid), 64'h0);
    chk("fl_o_ctrl",  64'(o_ctrl),  64'h0);
    chk("fl_o_ready", 64'(o_ready), 64'h1);
    i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("fl_no_entry7", 64'(o_valid), 64'h0);
    end

    // Saturation of the 2-bit counter, then clear during an ongoing stall.
    i_ready = 1'b0; clr_stat = 1'b1; cyc(); clr_stat = 1'b0;
    chk("sat_cleared", 64'(stall_cnt2), 64'h0);
    i_valid = 1'b1; i_data = 32'd9; i_ctrl = 4'h9; cyc();
    i_valid = 1'b0;
    begin
      logic [1:0] exp_sat [6];
      exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      for (int c = 0; c < 6; c++) begin
        cyc();
        chk("sat_cnt2", 64'(stall_cnt2), 64'(exp_sat[c]));
        chk("sat_cnt16", 64'(stall_cnt), 64'(c + 1));
      end
    end
    clr_stat = 1'b1; cyc(); clr_stat = 1'b0;
    chk("sat_clr", 64'(stall_cnt2), 64'h0);
    cyc();
    chk("sat_after_clr", 64'(stall_cnt2), 64'h1);
    i_ready = 1'b1; cyc();
    chk("sat_drained", 64'(o_valid), 64'h0);

    // Bubble control: one entry with ctrl=F, dequeued, then idle.
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 32'hAA; i_ctrl = 4'hF; cyc();
    i_valid = 1'b0;
    chk("bub_ctrl_live", 64'(o_ctrl), 64'hF);
    i_ready = 1'b1; cyc();
    chk("bub_o_valid", 64'(o_valid), 64'h0);
    chk("bub_o_ctrl",  64'(o_ctrl),  64'h0);

    // Reset asserted mid-stream with FULL occupancy.
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 32'd11; i_ctrl = 4'hB; cyc();
    i_data = 32'd12; i_ctrl = 4'hC; cyc();
    i_valid = 1'b0;
    chk("mr_full", 64'(o_ready), 64'h0);
    #2 reset = 1'b0;
    #1;
    sb_q.delete();
    chk("mr_o_valid", 64'(o_valid), 64'h0);
    chk("mr_o_ctrl",  64'(o_ctrl),  64'h0);
    chk("mr_o_data",  64'(o_data),  64'h0);
    chk("mr_o_ready", 64'(o_ready), 64'h1);
    chk("mr_stall",   64'(stall_cnt), 64'h0);
    cyc();
    reset = 1'b1;
    i_ready = 1'b1;
    cyc(); cyc();
    chk("idle_o_valid", 64'(o_valid), 64'h0);
    chk("idle_o_ctrl",  64'(o_ctrl),  64'h0);
    chk("idle_o_data",  64'(o_data),  64'h0);
    chk("idle_o_ready", 64'(o_ready), 64'h1);
    chk("idle_stall",   64'(stall_cnt), 64'h0);

    chk("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register for the five-stage core. It is the next generation of the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), with a separate payload bus and control bus, a valid/ready handshake, a two-entry skid buffer so that back-pressure is fully registered, synchronous flush for bubble insertion, and a saturating stall counter. One instance sits between each pair of pipeline stages. Control bits are always zero whenever the stage holds a bubble.

## Interface
- DATA_W, 128, payload width in bits (result, memory data, pc+4, immediate, ...); ≥1
- CTRL_W, 4, control width in bits (reg_write, mem_read, mem_to_reg, ...); ≥1
- CNT_W, 16, stall-counter width in bits; ≥2

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- flush  in  1  synchronous flush; discards all held entries and any same-cycle input
- clr_stat  in  1  synchronous clear of stall_cnt
- i_valid  in  1  upstream entry valid
- o_ready  out  1  stage can accept an entry; registered
- i_data  in  DATA_W  upstream payload
- i_ctrl  in  CTRL_W  upstream control
- o_valid  out  1  downstream entry valid
- i_ready  in  1  downstream accepts
- o_data  out  DATA_W  head payload
- o_ctrl  out  CTRL_W  head control; 0 when o_valid=0
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation
- Storage:
  - Main entry (m_valid, m_data, m_ctrl) drives o_valid, o_data and o_ctrl.
  - Skid entry (s_valid, s_data, s_ctrl).
  - o_ready = ~s_valid, taken directly from a flop.
- Handshake definitions: acc = i_valid & o_ready; deq = m_valid & i_ready.
- States are encoded as {m_valid, s_valid}: EMPTY=00, ONE=10, FULL=11. State 01 is illegal.
- EMPTY:
  - acc: main ← input; go to ONE.
- ONE:
  - acc & deq: main ← input; stay in ONE.
  - acc & ~deq: skid ← input; go to FULL.
  - ~acc & deq: go to EMPTY.
- FULL (o_ready=0, so acc cannot occur):
  - deq: main ← skid; go to ONE.
  - else: hold.
- Ordering: entries leave in acceptance order. Skid contents always exit before any later input.
- Bubble rule:
  - Whenever the main entry becomes invalid, m_ctrl ← 0 in the same edge.
  - Whenever the skid entry becomes invalid, s_ctrl ← 0 in the same edge.
  - Data registers may hold stale values.
- Flush:
  - At the edge: m_valid, s_valid, m_ctrl, s_ctrl ← 0; state goes to EMPTY.
  - Same-cycle acc and deq are ignored for storage purposes.
  - The downstream still sees the pre-flush head during the flush cycle, because outputs are registered.
- Stall counter:
  - Increments on each edge where o_valid & ~i_ready & ~flush.
  - Saturates at 2^CNT_W−1; does not wrap.
  - clr_stat has priority over increment; the result is 0.
- Reset (reset=0, asynchronous):
  - State goes to EMPTY.
  - All data, ctrl and stall_cnt registers are cleared to 0.
  - o_ready=1, o_valid=0, o_data=0, o_ctrl=0, stall_cnt=0.
  - Reset asserted mid-transfer discards all entries.
  - Release is synchronous to clk. The first acc can occur on the first rising edge with reset=1.

## Timing
- Latency: an input accepted at edge N appears on the outputs after edge N (one cycle).
- Throughput: one entry per cycle when i_ready stays high.
- o_ready has no combinational path from i_ready or i_valid.
  - A downstream stall is visible upstream one cycle later.
  - The skid entry absorbs the in-flight entry during that cycle.
- o_valid, o_data, o_ctrl and stall_cnt are all registered; no combinational input-to-output path.
- i_data and i_ctrl are sampled only when acc=1. i_ready is ignored when o_valid=0.
- flush and clr_stat are active-high and synchronous.

## Test plan
- Reset and idle:
  - Assert reset=0 mid-stream with FULL occupancy.
  - Outputs immediately become o_valid=0, o_ctrl=0, o_data=0, o_ready=1, stall_cnt=0.
  - After release with no input, outputs hold those values.
- Streaming:
  - Hold i_ready=1 and send i_valid=1 for 8 cycles with i_data=k, i_ctrl=k[3:0], k=1..8.
  - o_valid rises one cycle after the first accept.
  - Payloads emerge in order 1..8 on consecutive cycles; o_ready stays 1 throughout.
- Back-pressure and skid:
  - Stream 1,2,3,... and drop i_ready at cycle 3 for 4 cycles.
  - o_ready falls one cycle after the drop.
  - No payload is lost or duplicated; order is preserved.
  - stall_cnt=4 afterwards.
- Flush:
  - In FULL (entries 5,6), assert flush together with i_valid=1 (entry 7).
  - Next cycle: o_valid=0, o_ctrl=0, o_ready=1.
  - Entry 7 never appears downstream.
- Counter saturation:
  - With CNT_W=2, hold o_valid=1 and i_ready=0 for 6 cycles.
  - stall_cnt reads 1,2,3,3,3,3.
  - clr_stat for one cycle gives 0, even while the stall continues.
- Bubble control:
  - Send one entry with i_ctrl=4'hF, deq it, then leave i_valid=0.
  - The cycle after deq: o_valid=0 and o_ctrl=4'h0. o_data may be stale.
